// File: rtl/tlk2711_pkg.sv
// rtl/tlk2711_pkg.sv - shared constants and FSM state encoding for the TLK2711 test-mode checker
package tlk2711_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HUNT = 2'd1;
    localparam state_t ST_LOCK = 2'd2;

    localparam int          TEST_FRAME_BEATS    = 109;
    localparam logic [63:0] TEST_SEED           = 64'h0000000100020003;
    localparam logic [63:0] TEST_INC            = 64'h0004000400040004;
    localparam int          LOSS_OF_LOCK_THRESH = 4;

endpackage

// File: rtl/tlk2711_rx_data_checker_if.sv
// rtl/tlk2711_rx_data_checker_if.sv - RX FIFO read-side beat bus seen by the checker
interface tlk2711_rx_data_checker_if #(
    parameter int DATA_W = 64
);
    logic              valid;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data);
    modport slave  (input  valid, input  data);
endinterface

// File: rtl/tlk2711_lane_ref_gen.sv
// rtl/tlk2711_lane_ref_gen.sv - lane-wise seed/increment reference generator
// Each lane wraps modulo 2^LANE_W on its own; no carry crosses lane boundaries.
module tlk2711_lane_ref_gen #(
    parameter int              DATA_W = 64,
    parameter int              LANE_W = 16,
    parameter logic [DATA_W-1:0] SEED = '0,
    parameter logic [DATA_W-1:0] INC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] ref_data
);
    localparam int LANES = DATA_W / LANE_W;

    logic [DATA_W-1:0] ref_q;
    logic [DATA_W-1:0] ref_inc;

    always_comb begin
        ref_inc = '0;
        for (int l = 0; l < LANES; l++) begin
            ref_inc[l*LANE_W +: LANE_W] = ref_q[l*LANE_W +: LANE_W] + INC[l*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= SEED;
        end else if (load) begin
            ref_q <= SEED;
        end else if (advance) begin
            ref_q <= ref_inc;
        end
    end

    assign ref_data = ref_q;

endmodule

// File: rtl/tlk2711_rx_data_checker.sv
// rtl/tlk2711_rx_data_checker.sv - RX FIFO test-pattern checker with frame lock and statistics
// Input stage registers the beat; compare and state/statistics update on the following edge.
module tlk2711_rx_data_checker
    import tlk2711_pkg::*;
#(
    parameter int                DATA_W      = 64,
    parameter int                LANE_W      = 16,
    parameter int                FRAME_BEATS = TEST_FRAME_BEATS,
    parameter int                LAST_LANES  = 3,
    parameter logic [DATA_W-1:0] SEED        = TEST_SEED,
    parameter logic [DATA_W-1:0] INC         = TEST_INC,
    parameter int                CNT_W       = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_soft_rst,
    input  logic                       i_check_ena,
    input  logic                       i_cnt_clr,
    tlk2711_rx_data_checker_if.slave   rx,
    output logic                       o_locked,
    output logic                       o_check_error,
    output logic                       o_error_sticky,
    output logic [CNT_W-1:0]           o_err_cnt,
    output logic [CNT_W-1:0]           o_frame_cnt,
    output logic [7:0]                 o_first_err_beat
);
    localparam int LANES = DATA_W / LANE_W;
    localparam int IDX_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int BAD_W = (LOSS_OF_LOCK_THRESH > 1) ? $clog2(LOSS_OF_LOCK_THRESH) : 1;

    logic              ena_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    state_t            state, state_n;
    logic [IDX_W-1:0]  beat_idx, idx_n;
    logic [BAD_W-1:0]  bad_run, bad_n;

    logic [DATA_W-1:0] ref_data;
    logic              ref_load;
    logic              ref_adv;

    logic              is_last;
    logic              mismatch;
    logic              seed_match;
    logic              err_n;
    logic              frame_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (i_soft_rst) begin
            ena_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            ena_q   <= i_check_ena;
            valid_q <= rx.valid;
            data_q  <= rx.data;
        end
    end

    tlk2711_lane_ref_gen #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W),
        .SEED   (SEED),
        .INC    (INC)
    ) u_ref_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ref_load | i_soft_rst),
        .advance  (ref_adv),
        .ref_data (ref_data)
    );

    assign is_last    = (beat_idx == IDX_W'(FRAME_BEATS - 1));
    assign seed_match = (data_q == SEED);

    // Lanes below the top LAST_LANES of the final beat carry padding and are ignored.
    always_comb begin
        mismatch = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if ((data_q[l*LANE_W +: LANE_W] != ref_data[l*LANE_W +: LANE_W]) &&
                (!is_last || (l >= LANES - LAST_LANES))) begin
                mismatch = 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = beat_idx;
        bad_n     = bad_run;
        ref_load  = 1'b0;
        ref_adv   = 1'b0;
        err_n     = 1'b0;
        frame_end = 1'b0;
        if (!ena_q) begin
            state_n  = ST_IDLE;
            idx_n    = '0;
            bad_n    = '0;
            ref_load = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n  = ST_HUNT;
                    idx_n    = '0;
                    bad_n    = '0;
                    ref_load = 1'b1;
                end
                ST_HUNT: begin
                    if (valid_q && seed_match) begin
                        state_n = ST_LOCK;
                        if (is_last) begin
                            idx_n    = '0;
                            ref_load = 1'b1;
                        end else begin
                            idx_n   = beat_idx + 1'b1;
                            ref_adv = 1'b1;
                        end
                    end
                end
                ST_LOCK: begin
                    if (valid_q) begin
                        err_n     = mismatch;
                        frame_end = is_last;
                        if (is_last) begin
                            idx_n    = '0;
                            ref_load = 1'b1;
                        end else begin
                            idx_n   = beat_idx + 1'b1;
                            ref_adv = 1'b1;
                        end
                        if (!mismatch) begin
                            bad_n = '0;
                        end else if (bad_run == BAD_W'(LOSS_OF_LOCK_THRESH - 1)) begin
                            // Lost alignment: restart the hunt from SEED.
                            state_n  = ST_HUNT;
                            idx_n    = '0;
                            bad_n    = '0;
                            ref_load = 1'b1;
                            ref_adv  = 1'b0;
                        end else begin
                            bad_n = bad_run + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n  = ST_IDLE;
                    idx_n    = '0;
                    bad_n    = '0;
                    ref_load = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            beat_idx <= '0;
            bad_run  <= '0;
        end else if (i_soft_rst) begin
            state    <= ST_IDLE;
            beat_idx <= '0;
            bad_run  <= '0;
        end else begin
            state    <= state_n;
            beat_idx <= idx_n;
            bad_run  <= bad_n;
        end
    end

    // The error pulse is independent of i_cnt_clr; only the accumulated statistics clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_check_error    <= 1'b0;
            o_error_sticky   <= 1'b0;
            o_err_cnt        <= '0;
            o_frame_cnt      <= '0;
            o_first_err_beat <= '0;
        end else if (i_soft_rst) begin
            o_check_error    <= 1'b0;
            o_error_sticky   <= 1'b0;
            o_err_cnt        <= '0;
            o_frame_cnt      <= '0;
            o_first_err_beat <= '0;
        end else begin
            o_check_error <= err_n;
            if (i_cnt_clr) begin
                o_error_sticky   <= 1'b0;
                o_err_cnt        <= '0;
                o_frame_cnt      <= '0;
                o_first_err_beat <= '0;
            end else begin
                if (err_n) begin
                    if (o_err_cnt != {CNT_W{1'b1}}) begin
                        o_err_cnt <= o_err_cnt + 1'b1;
                    end
                    if (!o_error_sticky) begin
                        o_error_sticky   <= 1'b1;
                        o_first_err_beat <= 8'(beat_idx);
                    end
                end
                if (frame_end && (o_frame_cnt != {CNT_W{1'b1}})) begin
                    o_frame_cnt <= o_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign o_locked = (state == ST_LOCK);

endmodule

// File: tb/tb_tlk2711_rx_data_checker.sv
// tb/tb_tlk2711_rx_data_checker.sv - scoreboard bench for the TLK2711 RX data checker
module tb_tlk2711_rx_data_checker;
    import tlk2711_pkg::*;

    localparam int          DW    = 64;
    localparam int          LW    = 16;
    localparam int          LANES = DW / LW;
    localparam int          FB    = TEST_FRAME_BEATS;
    localparam int          LL    = 3;
    localparam int          CW    = 5;
    localparam int          CMAX  = (1 << CW) - 1;
    localparam logic [63:0] SEED  = TEST_SEED;
    localparam logic [63:0] INC   = TEST_INC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic soft_rst = 1'b0;
    logic check_ena = 1'b0;
    logic cnt_clr = 1'b0;
    logic locked, check_error, error_sticky;
    logic [CW-1:0] err_cnt, frame_cnt;
    logic [7:0] first_err_beat;

    tlk2711_rx_data_checker_if #(.DATA_W(DW)) rx();

    tlk2711_rx_data_checker #(
        .DATA_W(DW), .LANE_W(LW), .FRAME_BEATS(FB), .LAST_LANES(LL),
        .SEED(SEED), .INC(INC), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_soft_rst(soft_rst), .i_check_ena(check_ena),
        .i_cnt_clr(cnt_clr), .rx(rx), .o_locked(locked), .o_check_error(check_error),
        .o_error_sticky(error_sticky), .o_err_cnt(err_cnt), .o_frame_cnt(frame_cnt),
        .o_first_err_beat(first_err_beat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            due;
        logic          err;
        logic          lock;
        logic          sticky;
        logic [CW-1:0] ecnt;
        logic [CW-1:0] fcnt;
        logic [7:0]    first;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model: mode 0 idle, 1 hunting, 2 locked; reference value computed from beat index.
    int          m_mode, m_idx, m_bad, m_ecnt, m_fcnt, m_first;
    bit          m_sticky;
    logic        p_ena, p_valid;
    logic [63:0] p_data;
    logic        ena_lvl;

    function automatic logic [63:0] ref_beat(input int idx);
        logic [63:0] r, s, inc;
        s = SEED;
        inc = INC;
        r = '0;
        for (int l = 0; l < LANES; l++)
            r[l*LW +: LW] = 16'(int'(s[l*LW +: LW]) + idx * int'(inc[l*LW +: LW]));
        return r;
    endfunction

    function automatic bit beat_bad(input int idx, input logic [63:0] d);
        logic [63:0] r;
        r = ref_beat(idx);
        for (int l = 0; l < LANES; l++)
            if ((idx != FB - 1 || l >= LANES - LL) && d[l*LW +: LW] != r[l*LW +: LW]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_bad = 0; m_ecnt = 0; m_fcnt = 0; m_first = 0; m_sticky = 0;
        p_ena = 0; p_valid = 0; p_data = '0;
    endtask

    // One DUT clock edge: the beat registered on the previous edge meets this cycle's controls.
    task automatic model_edge(input logic clr, input logic srst);
        bit err, fend, push;
        int cur;
        err = 0; fend = 0; push = 0; cur = m_idx;
        if (srst) begin
            model_reset();
            return;
        end
        if (!p_ena) begin
            m_mode = 0; m_idx = 0; m_bad = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (p_valid) begin
            push = 1;
            if (m_mode == 1) begin
                if (p_data == SEED) begin
                    m_mode = 2;
                    m_idx = (FB == 1) ? 0 : 1;
                end
            end else begin
                err  = beat_bad(cur, p_data);
                fend = (cur == FB - 1);
                m_idx = (cur + 1) % FB;
                m_bad = err ? m_bad + 1 : 0;
                if (m_bad == LOSS_OF_LOCK_THRESH) begin
                    m_mode = 1; m_idx = 0; m_bad = 0;
                end
            end
        end
        if (clr) begin
            m_ecnt = 0; m_fcnt = 0; m_first = 0; m_sticky = 0;
        end else begin
            if (err) begin
                if (m_ecnt < CMAX) m_ecnt++;
                if (!m_sticky) begin m_sticky = 1; m_first = cur % 256; end
            end
            if (fend && m_fcnt < CMAX) m_fcnt++;
        end
        if (push)
            sb.push_back('{cyc + 1, err, (m_mode == 2), m_sticky, CW'(m_ecnt), CW'(m_fcnt), 8'(m_first)});
    endtask

    task automatic drive(input logic ena, input logic v, input logic [63:0] d,
                         input logic clr, input logic srst);
        @(negedge clk);
        check_ena = ena; rx.valid = v; rx.data = d; cnt_clr = clr; soft_rst = srst;
        model_edge(clr, srst);
        if (srst) begin
            p_ena = 0; p_valid = 0; p_data = '0;
        end else begin
            p_ena = ena; p_valid = v; p_data = d;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(ena_lvl, 1'b0, 64'(0), 1'b0, 1'b0);
    endtask

    // Beats start..stop of a frame; beats in [bad_lo,bad_hi] get bit bad_bit (random if <0) flipped.
    task automatic send_frame(input int start, input int stop, input int gap, input int pct,
                              input int bad_lo, input int bad_hi, input int bad_bit,
                              input int clr_beat, input bit sat);
        logic [63:0] d;
        logic clr;
        int bit_n;
        clr = 0;
        for (int b = start; b <= stop; b++) begin
            d = ref_beat(b);
            if (b == FB - 1)
                for (int l = 0; l < LANES - LL; l++) d[l*LW +: LW] = 16'($urandom);
            bit_n = (bad_bit < 0) ? int'($urandom_range(63)) : bad_bit;
            if ((b >= bad_lo && b <= bad_hi) || (sat && (b % 4) != 0) ||
                (int'($urandom_range(99)) < pct))
                d = d ^ (64'd1 << bit_n);
            drive(1'b1, 1'b1, d, clr, 1'b0);
            clr = (b == clr_beat);
            for (int g = 0; g < gap; g++) begin
                drive(1'b1, 1'b0, {$urandom, $urandom}, clr, 1'b0);
                clr = 0;
            end
        end
        if (clr) drive(1'b1, 1'b0, 64'(0), 1'b1, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                chk("sb_err_pulse", check_error, mon_e.err);
                chk("sb_locked", locked, mon_e.lock);
                chk("sb_sticky", error_sticky, mon_e.sticky);
                chk("sb_err_cnt", err_cnt, mon_e.ecnt);
                chk("sb_frame_cnt", frame_cnt, mon_e.fcnt);
                chk("sb_first_err", first_err_beat, mon_e.first);
            end else begin
                chk("no_spurious_pulse", check_error, 1'b0);
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    chk("sb_missed_slot", 64'(sb[0].due), 64'(cyc));
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rx.valid = 1'b0;
        rx.data = '0;
        ena_lvl = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_locked", locked, 0);
        chk("rst_err_pulse", check_error, 0);
        chk("rst_sticky", error_sticky, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_first_err", first_err_beat, 0);
        rst_n = 1'b1;
        ena_lvl = 1'b1;
        idle(4);

        // clean frames from SEED
        repeat (3) send_frame(0, FB - 1, 0, 0, -1, -1, 0, -1, 0);
        idle(3);
        chk("t1_frame_cnt", frame_cnt, 3);
        chk("t1_err_cnt", err_cnt, 0);
        chk("t1_locked", locked, 1);

        // padding lane ignored; bit 16 of the last beat is a real error
        send_frame(0, FB - 1, 0, 0, -1, -1, 0, -1, 0);
        send_frame(0, FB - 1, 0, 0, FB - 1, FB - 1, 16, -1, 0);
        idle(3);
        chk("t2_err_cnt", err_cnt, 1);
        chk("t2_first_err", first_err_beat, FB - 1);

        // corrupt beat 5 of frame 2 after a statistics clear
        drive(1'b1, 1'b0, 64'(0), 1'b1, 1'b0);
        send_frame(0, FB - 1, 0, 0, -1, -1, 0, -1, 0);
        send_frame(0, FB - 1, 0, 0, 5, 5, 40, -1, 0);
        send_frame(0, FB - 1, 0, 0, -1, -1, 0, -1, 0);
        idle(3);
        chk("t3_sticky", error_sticky, 1);
        chk("t3_first_err", first_err_beat, 5);
        chk("t3_err_cnt", err_cnt, 1);
        chk("t3_locked", locked, 1);

        // re-enable and join mid-frame, then four bad beats in a row
        ena_lvl = 1'b0; idle(3);
        chk("t4_unlocked_when_disabled", locked, 0);
        ena_lvl = 1'b1; idle(3);
        send_frame(40, FB - 1, 0, 0, -1, -1, 0, -1, 0);
        send_frame(0, FB - 1, 0, 0, 10, 13, -1, -1, 0);
        idle(3);
        chk("t4_err_cnt", err_cnt, 5);
        chk("t4_lock_lost", locked, 0);

        // sparse valid and randomised traffic
        drive(1'b1, 1'b0, 64'(0), 1'b1, 1'b0);
        send_frame(0, FB - 1, 3, 0, -1, -1, 0, -1, 0);
        idle(3);
        chk("t5_frame_cnt", frame_cnt, 1);
        chk("t5_err_cnt", err_cnt, 0);
        for (int f = 0; f < 4; f++)
            send_frame(0, FB - 1, int'($urandom_range(2)), 2, -1, -1, -1, -1, 0);

        // clear coinciding with an error, then saturation
        send_frame(0, FB - 1, 0, 0, 20, 20, 33, 20, 0);
        idle(3);
        chk("t6_clr_err_cnt", err_cnt, 0);
        chk("t6_clr_sticky", error_sticky, 0);
        send_frame(0, FB - 1, 0, 0, -1, -1, 0, -1, 1);
        idle(3);
        chk("t6_err_sat", err_cnt, CMAX);

        // asynchronous reset mid-frame
        send_frame(0, 50, 0, 0, 30, 30, 7, -1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_frame_cnt", frame_cnt, 0);
        chk("arst_sticky", error_sticky, 0);
        sb.delete();
        ena_lvl = 1'b0;
        model_reset();
        check_ena = 1'b0; rx.valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ena_lvl = 1'b1;
        idle(4);
        send_frame(0, FB - 1, 0, 0, -1, -1, 0, -1, 0);
        idle(3);
        chk("arst_relock_frames", frame_cnt, 1);

        // soft reset mid-frame
        send_frame(0, 30, 0, 0, 12, 12, -1, -1, 0);
        drive(1'b1, 1'b0, 64'(0), 1'b0, 1'b1);
        idle(1);
        chk("srst_locked", locked, 0);
        chk("srst_err_cnt", err_cnt, 0);
        chk("srst_frame_cnt", frame_cnt, 0);
        idle(4);
        send_frame(0, FB - 1, 0, 0, -1, -1, 0, -1, 0);
        idle(4);
        chk("srst_relock_frames", frame_cnt, 1);
        chk("sb_drained", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
